btn_irq_ctrl: RTL

Button input stage feeding the CPU: synchronises and debounces the raw `btn` pins, detects programmable edges, latches them as pending interrupts and drives the CPU `irq` line. A bus slave on bank `8'h04` exposes state, pending, enable and edge-select registers. The same handshake as the other bus peripherals (`video`, `uart`) applies. Replaces the direct `btn` readback and the hard-wired `irq = btn[6]`.

---
 rtl/btn_irq_ctrl_pkg.sv | 25 ++
 rtl/btn_sync_debounce.sv | 48 ++++
 rtl/btn_irq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/btn_irq_ctrl_pkg.sv
// Shared definitions for the button interrupt controller.
//   - register select codes (byte address bits [3:2])
//   - EDGE register field positions and reset value
package btn_irq_ctrl_pkg;

  localparam logic [1:0] BTN_REG_STATE  = 2'd0;  // 0x0
  localparam logic [1:0] BTN_REG_PEND   = 2'd1;  // 0x4
  localparam logic [1:0] BTN_REG_ENABLE = 2'd2;  // 0x8
  localparam logic [1:0] BTN_REG_EDGE   = 2'd3;  // 0xC

  localparam int BTN_EDGE_RISE_LSB = 0;
  localparam int BTN_EDGE_FALL_LSB = 16;

  // Rise detection on for every button, fall detection off.
  localparam logic [31:0] BTN_EDGE_RST = 32'h0000_FFFF;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] btn_byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// One button bit: 2-FF synchroniser followed (with BTN_IRQ_DEBOUNCE_EN)
// by a two-sample debouncer clocked by a shared tick.
// Ports:
//   clk, rst_i   clock, synchronous active-low reset
//   tick_i       sample strobe from the parent prescaler (debounce build only)
//   btn_i        raw asynchronous pin
//   state_o      debounced (or merely synchronised) level
// Macro: BTN_IRQ_DEBOUNCE_EN selects the debounced build.
module btn_sync_debounce
  import btn_irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
`ifdef BTN_IRQ_DEBOUNCE_EN
  input  logic tick_i,
`endif
  input  logic btn_i,
  output logic state_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

`ifdef BTN_IRQ_DEBOUNCE_EN
  logic samp_q, level_q;

  // The level only moves when two consecutive ticks agree, so any
  // excursion shorter than one tick period is seen at most once.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      samp_q  <= 1'b0;
      level_q <= 1'b0;
    end else if (tick_i) begin
      samp_q <= sync_q[1];
      if (sync_q[1] == samp_q && sync_q[1] != level_q) level_q <= sync_q[1];
    end
  end

  assign state_o = level_q;
`else
  assign state_o = sync_q[1];
`endif

endmodule

// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller: synchronise/debounce buttons, detect
// selected edges, latch pending bits and drive a level interrupt.
// Bus slave registers (adr_i[3:2]): 0 STATE (RO), 1 PEND (W1C),
// 2 ENABLE (RW), 3 EDGE (RW, rise [NUM_BTN-1:0], fall [16+:NUM_BTN]).
// Ports:
//   clk, rst_i                 clock, synchronous active-low reset
//   btn_i[NUM_BTN]             raw active-high button pins
//   adr_i, dat_i, sel_i, we_i, stb_i   bus request
//   ack_o, dat_o               bus response (ack one cycle after stb)
//   irq_o                      registered level interrupt
// Macro: BTN_IRQ_DEBOUNCE_EN enables the prescaler and debouncer.
module btn_irq_ctrl
  import btn_irq_ctrl_pkg::*;
#(
  parameter int NUM_BTN         = 7,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [3:0]         adr_i,
  input  logic [31:0]        dat_i,
  input  logic [3:0]         sel_i,
  input  logic               we_i,
  input  logic               stb_i,
  output logic               ack_o,
  output logic [31:0]        dat_o,
  output logic               irq_o
);

  logic [NUM_BTN-1:0] state;

`ifdef BTN_IRQ_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick  = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_sync_debounce u_bit (
      .clk     (clk),
      .rst_i   (rst_i),
`ifdef BTN_IRQ_DEBOUNCE_EN
      .tick_i  (tick),
`endif
      .btn_i   (btn_i[g]),
      .state_o (state[g])
    );
  end

  logic [NUM_BTN-1:0] state_prev_q, pend_q, pend_d, en_q, en_d;
  logic [NUM_BTN-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [NUM_BTN-1:0] set_v, clr_v, m_lo, m_hi, d_lo, d_hi;
  logic               ack_q, ack_d, irq_q, irq_d;
  logic [31:0]        dat_q, dat_d, wmask, rdata;
  logic               access, wr, rd;
  logic [1:0]         reg_sel;
  logic               unused_adr;

  assign unused_adr = ^adr_i[1:0];
  assign reg_sel    = adr_i[3:2];
  assign access     = stb_i & ~ack_q;
  assign wr         = access & we_i;
  assign rd         = access & ~we_i;
  assign wmask      = btn_byte_mask(sel_i);
  assign m_lo       = wmask[BTN_EDGE_RISE_LSB +: NUM_BTN];
  assign m_hi       = wmask[BTN_EDGE_FALL_LSB +: NUM_BTN];
  assign d_lo       = dat_i[BTN_EDGE_RISE_LSB +: NUM_BTN];
  assign d_hi       = dat_i[BTN_EDGE_FALL_LSB +: NUM_BTN];

  always_comb begin
    set_v  = (state & ~state_prev_q & rise_q) | (~state & state_prev_q & fall_q);
    clr_v  = '0;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    if (wr) begin
      case (reg_sel)
        BTN_REG_PEND:   clr_v = d_lo & m_lo;
        BTN_REG_ENABLE: en_d  = (en_q & ~m_lo) | (d_lo & m_lo);
        BTN_REG_EDGE: begin
          rise_d = (rise_q & ~m_lo) | (d_lo & m_lo);
          fall_d = (fall_q & ~m_hi) | (d_hi & m_hi);
        end
        default: ;
      endcase
    end
    // Set after clear: a new edge is never lost to a concurrent W1C.
    pend_d = (pend_q & ~clr_v) | set_v;

    case (reg_sel)
      BTN_REG_STATE:  rdata = 32'(state);
      BTN_REG_PEND:   rdata = 32'(pend_q);
      BTN_REG_ENABLE: rdata = 32'(en_q);
      default:        rdata = 32'(rise_q) | (32'(fall_q) << BTN_EDGE_FALL_LSB);
    endcase
    dat_d = rd ? (rdata & wmask) : dat_q;
    ack_d = stb_i & ~ack_q;
    irq_d = |(pend_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_prev_q <= '0;
      pend_q       <= '0;
      en_q         <= '0;
      rise_q       <= BTN_EDGE_RST[BTN_EDGE_RISE_LSB +: NUM_BTN];
      fall_q       <= BTN_EDGE_RST[BTN_EDGE_FALL_LSB +: NUM_BTN];
      ack_q        <= 1'b0;
      dat_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_prev_q <= state;
      pend_q       <= pend_d;
      en_q         <= en_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      irq_q        <= irq_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule
